// File: rtl/uart_tx_fifo_if.sv
// Producer/transmitter-side signal bundle for uart_tx_fifo.
// master drives pushes and tx_done; slave is the FIFO itself.
interface uart_tx_fifo_if #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
);
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          flush;
    logic          clr_ovf;
    logic          tx_done;
    logic          trmt;
    logic [7:0]    tx_data;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          busy;

    modport master (
        output wr_en, wr_data, flush, clr_ovf, tx_done,
        input  trmt, tx_data, full, empty, count, overflow, busy
    );

    modport slave (
        input  wr_en, wr_data, flush, clr_ovf, tx_done,
        output trmt, tx_data, full, empty, count, overflow, busy
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter: pops one byte per frame,
// strobes trmt once, then waits for tx_done before the next launch.
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_tx_fifo_if.slave  bus
);
    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [7:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;
    logic            r_trmt;
    logic [7:0]      r_tx_data;
    logic            r_ovf;
    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_launch;
    logic            w_busy;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);
    assign w_push  = bus.wr_en && !w_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // r_trmt guard hides the tx_done left high by the previous frame
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: if (w_launch) w_state_nxt = S_WAIT;
            S_WAIT: if (bus.tx_done && !r_trmt) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_launch = (r_state == S_IDLE) && !w_empty && !bus.flush;
        w_busy   = (r_state != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (bus.flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)   r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_launch) r_rd_ptr <= r_rd_ptr + 1'b1;
            unique case ({w_push, w_launch})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !bus.flush) r_mem[r_wr_ptr] <= bus.wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_trmt    <= 1'b0;
            r_tx_data <= 8'h00;
        end else begin
            r_trmt <= w_launch;
            if (w_launch) r_tx_data <= r_mem[r_rd_ptr];
        end
    end

    // a rejected push in the same cycle as clr_ovf keeps the flag set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    r_ovf <= 1'b0;
        else if (bus.wr_en && w_full)  r_ovf <= 1'b1;
        else if (bus.clr_ovf)          r_ovf <= 1'b0;
    end

    assign bus.trmt     = r_trmt;
    assign bus.tx_data  = r_tx_data;
    assign bus.full     = w_full;
    assign bus.empty    = w_empty;
    assign bus.count    = r_count;
    assign bus.overflow = r_ovf;
    assign bus.busy     = w_busy;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised bench for uart_tx_fifo against a queue-based reference
// model, with a transmitter model driving tx_done.
module tb_uart_tx_fifo;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int N     = 20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_tx_fifo_if #(.DEPTH(DEPTH), .AW(AW)) u_if ();

    uart_tx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
    );

    // transmitter model: tx_done drops after trmt, rises N cycles later
    logic tb_done = 1'b1;
    logic stall   = 1'b0;
    int   done_cnt = 0;
    assign u_if.tx_done = tb_done;

    always @(posedge clk) begin
        if (u_if.trmt) begin
            tb_done  <= 1'b0;
            done_cnt <= N;
        end else if (!tb_done && !stall) begin
            if (done_cnt <= 1) tb_done <= 1'b1;
            else               done_cnt <= done_cnt - 1;
        end
    end

    logic [7:0] q[$];
    logic [7:0] sent[$];
    logic       m_busy = 1'b0;
    logic       m_trmt = 1'b0;
    logic       m_ovf  = 1'b0;
    logic [7:0] m_txd  = 8'h00;
    int cyc = 0;
    int last_trmt = -1000;
    int n_chk = 0;
    int n_fail = 0;

    task automatic tick();
        int   pre_size;
        logic launch;
        logic pre_done;
        logic acc;
        logic [14:0] got;
        logic [14:0] exp;
        pre_size = q.size();
        pre_done = tb_done;
        launch   = !m_busy && (pre_size > 0) && !u_if.flush;
        acc      = u_if.wr_en && (pre_size < DEPTH);
        @(posedge clk);
        #1;
        cyc++;
        if (launch)                              m_busy = 1'b1;
        else if (m_busy && pre_done && !m_trmt)  m_busy = 1'b0;
        m_trmt = launch;
        if (launch) begin
            m_txd = q.pop_front();
            sent.push_back(m_txd);
        end
        if (u_if.flush)  q.delete();
        else if (acc)    q.push_back(u_if.wr_data);
        if (u_if.wr_en && pre_size == DEPTH) m_ovf = 1'b1;
        else if (u_if.clr_ovf)               m_ovf = 1'b0;
        got = {u_if.trmt, u_if.tx_data, u_if.count, u_if.empty};
        exp = {m_trmt, m_txd, 5'(q.size()), q.size() == 0};
        n_chk++;
        if (got !== exp || u_if.full !== (q.size() == DEPTH) ||
            u_if.overflow !== m_ovf || u_if.busy !== m_busy) begin
            n_fail++;
            $display("FAIL model cyc=%0d trmt/data/cnt/empty got %h exp %h full %b ovf %b/%b busy %b/%b",
                     cyc, got, exp, u_if.full, u_if.overflow, m_ovf,
                     u_if.busy, m_busy);
        end
        if (u_if.trmt === 1'b1) begin
            n_chk++;
            if (cyc - last_trmt < N + 2) begin
                n_fail++;
                $display("FAIL trmt_gap got %0d need >= %0d",
                         cyc - last_trmt, N + 2);
            end
            last_trmt = cyc;
        end
    endtask

    task automatic push(input logic [7:0] d);
        u_if.wr_en   = 1'b1;
        u_if.wr_data = d;
        tick();
        u_if.wr_en = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int k;
        k = 0;
        while ((q.size() != 0 || m_busy) && k < bound) begin
            tick();
            k++;
        end
        n_chk++;
        if (q.size() != 0 || m_busy) begin
            n_fail++;
            $display("FAIL drain_timeout left %0d busy %b", q.size(), m_busy);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_busy    = 1'b0;
        m_trmt    = 1'b0;
        m_ovf     = 1'b0;
        m_txd     = 8'h00;
        last_trmt = -1000;
    endtask

    task automatic test_reset();
        u_if.wr_en   = 1'b0;
        u_if.wr_data = 8'h00;
        u_if.flush   = 1'b0;
        u_if.clr_ovf = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if ({u_if.trmt, u_if.tx_data, u_if.count, u_if.empty, u_if.full,
             u_if.overflow, u_if.busy} !== {1'b0, 8'h00, 5'd0, 4'b1000}) begin
            n_fail++;
            $display("FAIL reset_state trmt %b data %h cnt %0d e %b f %b o %b b %b",
                     u_if.trmt, u_if.tx_data, u_if.count, u_if.empty,
                     u_if.full, u_if.overflow, u_if.busy);
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_single();
        push(8'hA5);
        n_chk++;
        if (u_if.count !== 5'd1 || u_if.trmt !== 1'b0) begin
            n_fail++;
            $display("FAIL single_push cnt %0d trmt %b need 1/0",
                     u_if.count, u_if.trmt);
        end
        tick();
        n_chk++;
        if (u_if.trmt !== 1'b1 || u_if.tx_data !== 8'hA5 ||
            u_if.count !== 5'd0 || u_if.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_launch trmt %b data %h cnt %0d busy %b need 1/a5/0/1",
                     u_if.trmt, u_if.tx_data, u_if.count, u_if.busy);
        end
        wait_idle(100);
        n_chk++;
        if (u_if.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_idle busy %b need 0", u_if.busy);
        end
    endtask

    task automatic test_back_to_back();
        int base;
        base = sent.size();
        push(8'h11);
        push(8'h22);
        push(8'h33);
        wait_idle(200);
        n_chk++;
        if (sent.size() != base + 3 || sent[base] !== 8'h11 ||
            sent[base+1] !== 8'h22 || sent[base+2] !== 8'h33) begin
            n_fail++;
            $display("FAIL b2b_order got %0d bytes need 3 in order 11 22 33",
                     sent.size() - base);
        end
    endtask

    task automatic test_overflow();
        stall = 1'b1;
        push(8'h00);
        tick();
        for (int i = 0; i < DEPTH + 2; i++) push(8'($urandom));
        n_chk++;
        if (u_if.full !== 1'b1 || u_if.count !== 5'd16 ||
            u_if.overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_full full %b cnt %0d ovf %b need 1/16/1",
                     u_if.full, u_if.count, u_if.overflow);
        end
        u_if.clr_ovf = 1'b1;
        tick();
        u_if.clr_ovf = 1'b0;
        n_chk++;
        if (u_if.overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear ovf %b need 0", u_if.overflow);
        end
        stall = 1'b0;
        wait_idle(DEPTH * (N + 4) + 100);
    endtask

    task automatic test_wrap();
        int base;
        int pushes;
        int k;
        base   = sent.size();
        pushes = 0;
        k      = 0;
        while (pushes < 40 && k < 4000) begin
            if (q.size() < DEPTH && $urandom_range(0, 3) == 0) begin
                push(8'($urandom));
                pushes++;
            end else begin
                tick();
            end
            k++;
        end
        wait_idle(DEPTH * (N + 4) + 100);
        n_chk++;
        if (sent.size() - base != 40) begin
            n_fail++;
            $display("FAIL wrap_count got %0d bytes need 40",
                     sent.size() - base);
        end
    endtask

    task automatic test_flush();
        int base;
        logic [7:0] held;
        for (int i = 0; i < 6; i++) push(8'(8'h60 + i));
        held = m_txd;
        n_chk++;
        if (u_if.count !== 5'd5 || u_if.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_pre cnt %0d busy %b need 5/1",
                     u_if.count, u_if.busy);
        end
        base = sent.size();
        u_if.flush   = 1'b1;
        u_if.wr_en   = 1'b1;
        u_if.wr_data = 8'hEE;
        tick();
        u_if.flush = 1'b0;
        u_if.wr_en = 1'b0;
        n_chk++;
        if (u_if.count !== 5'd0 || u_if.empty !== 1'b1 ||
            u_if.busy !== 1'b1 || u_if.tx_data !== held) begin
            n_fail++;
            $display("FAIL flush_post cnt %0d empty %b busy %b data %h need 0/1/1/%h",
                     u_if.count, u_if.empty, u_if.busy, u_if.tx_data, held);
        end
        repeat (2 * N) tick();
        n_chk++;
        if (sent.size() != base || u_if.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_after launches %0d busy %b need 0/0",
                     sent.size() - base, u_if.busy);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        push(8'h71);
        push(8'h72);
        push(8'h73);
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (u_if.trmt !== 1'b0 || u_if.count !== 5'd0 ||
            u_if.tx_data !== 8'h00 || u_if.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid trmt %b cnt %0d data %h busy %b need 0/0/00/0",
                     u_if.trmt, u_if.count, u_if.tx_data, u_if.busy);
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        base = sent.size();
        repeat (N + 10) tick();
        n_chk++;
        if (sent.size() != base) begin
            n_fail++;
            $display("FAIL reset_relaunch launches %0d need 0",
                     sent.size() - base);
        end
        push(8'h5A);
        wait_idle(100);
        n_chk++;
        if (sent.size() != base + 1 || sent[base] !== 8'h5A) begin
            n_fail++;
            $display("FAIL reset_newpush got %0d bytes need 1 (5a)",
                     sent.size() - base);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_wrap();
        test_flush();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired after %0d cycles", cyc);
        $fatal(1);
    end
endmodule
